// File: rtl/sysid_boot_checker.sv
// Boot-time image check: reads sysid word 0 (ID) and word 1 (timestamp) over Avalon-MM and compares both.
// Optional retry of a failed check is enabled by defining SYSID_CHECK_RETRY_EN.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h00000001,
    parameter logic [31:0] EXPECTED_TS    = 32'd1501838636,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RD_ID = 2'd1;
    localparam logic [1:0] RD_TS = 2'd2;
    localparam logic [1:0] FIN   = 2'd3;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("sysid_boot_checker: TIMEOUT_CYCLES must be 1..65535");
    end
    if (MAX_RETRIES > 15) begin : g_bad_retries
        $error("sysid_boot_checker: MAX_RETRIES must be 0..15");
    end

    logic [1:0]  state;
    logic [15:0] tmo_cnt;
    logic        fin_pass;
    logic        retry_now;

    assign fin_pass = id_ok & ts_ok & ~timeout;

`ifdef SYSID_CHECK_RETRY_EN
    logic [3:0] retry_cnt;
    assign retry_now = ~fin_pass & (retry_cnt < 4'(MAX_RETRIES));
`else
    assign retry_now = 1'b0;
`endif

    // NOTE: every register here is updated with <= so all of them see the pre-edge values of
    // id_ok/ts_ok/timeout; a blocking write would let FIN compute pass from half-updated state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RD_ID;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            captured_id <= '0;
            captured_ts <= '0;
            tmo_cnt     <= '0;
`ifdef SYSID_CHECK_RETRY_EN
            retry_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RD_ID;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        pass    <= 1'b0;
                        id_ok   <= 1'b0;
                        ts_ok   <= 1'b0;
                        timeout <= 1'b0;
                        tmo_cnt <= '0;
`ifdef SYSID_CHECK_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                RD_ID, RD_TS: begin
                    // Entering RD_ID leaves avm_read low for one cycle; this launches the ID read.
                    if (!avm_read) begin
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        busy        <= 1'b1;
                    end else if (!avm_waitrequest) begin
                        tmo_cnt <= '0;
                        if (state == RD_ID) begin
                            captured_id <= avm_readdata;
                            id_ok       <= (avm_readdata == EXPECTED_ID);
                            avm_address <= 1'b1;
                            state       <= RD_TS;
                        end else begin
                            captured_ts <= avm_readdata;
                            ts_ok       <= (avm_readdata == EXPECTED_TS);
                            avm_read    <= 1'b0;
                            avm_address <= 1'b0;
                            state       <= FIN;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout     <= 1'b1;
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        tmo_cnt     <= '0;
                        state       <= FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: begin
                    if (retry_now) begin
`ifdef SYSID_CHECK_RETRY_EN
                        retry_cnt <= retry_cnt + 4'd1;
`endif
                        id_ok   <= 1'b0;
                        ts_ok   <= 1'b0;
                        timeout <= 1'b0;
                        state   <= RD_ID;
                    end else begin
                        done  <= 1'b1;
                        pass  <= fin_pass;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
